spike_rate_encoder: RTL and testbench

Stochastic rate encoder that turns a multi-bit intensity sample into a binary spike train for the leaky-integrate-and-fire neuron input. Each accepted sample is emitted over a fixed window of STEPS timesteps. Each step fires with probability ≈ value/2^W, decided by a free-running LFSR. The block sits between the pixel/feature source (valid/ready) and the neuron's 1-bit input, and reports the emitted spike count per sample for checking.

---
 rtl/spike_rate_encoder.sv | 106 ++++++++++
 tb/tb_spike_rate_encoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/spike_rate_encoder.sv
// Stochastic rate encoder: turns one intensity sample into a STEPS-long
// binary spike train, firing each step with probability ~ value/2^W.
module spike_rate_encoder #(
    parameter int unsigned W     = 8,
    parameter int unsigned STEPS = 16,
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned CW    = $clog2(STEPS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_value,
    input  logic          step_en,
    output logic          spike_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] spike_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W-1:0]  VAL_MAX   = {W{1'b1}};
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);
    localparam logic [15:0]   TAPS      = 16'hB400;

    state_t        state, state_nxt;
    logic [W-1:0]  val_r, val_nxt;
    logic [15:0]   lfsr, lfsr_nxt;
    logic [CW-1:0] step_cnt, step_nxt;
    logic [CW-1:0] count_nxt;
    logic          spike_nxt;
    logic          fire;

    // Full-scale always fires; otherwise compare against the current LFSR draw.
    assign fire = (val_r == VAL_MAX) || (val_r > lfsr[W-1:0]);

    // State and datapath registers; the LFSR is only reseeded by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            val_r       <= '0;
            lfsr        <= SEED;
            step_cnt    <= '0;
            spike_count <= '0;
            spike_out   <= 1'b0;
        end else begin
            state       <= state_nxt;
            val_r       <= val_nxt;
            lfsr        <= lfsr_nxt;
            step_cnt    <= step_nxt;
            spike_count <= count_nxt;
            spike_out   <= spike_nxt;
        end
    end

    // Next-state, datapath update and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        val_nxt   = val_r;
        lfsr_nxt  = lfsr;
        step_nxt  = step_cnt;
        count_nxt = spike_count;
        spike_nxt = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    val_nxt   = in_value;
                    step_nxt  = '0;
                    count_nxt = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (step_en) begin
                    spike_nxt = fire;
                    lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
                    count_nxt = spike_count + CW'(fire);
                    step_nxt  = step_cnt + CW'(1);
                    if (step_cnt == LAST_STEP) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder with a reference LFSR/compare model.
module tb_spike_rate_encoder;

    localparam int unsigned W     = 8;
    localparam int unsigned STEPS = 16;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_value;
    logic          step_en;
    logic          spike_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] spike_count;

    int checks   = 0;
    int failures = 0;
    logic [15:0] m_lfsr;

    spike_rate_encoder #(
        .W(W), .STEPS(STEPS), .SEED(SEED), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .step_en(step_en), .spike_out(spike_out),
        .busy(busy), .done(done), .spike_count(spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic fire_m(input logic [7:0] v, input logic [15:0] l);
        return (v == 8'hFF) || (v > l[7:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one sample; step_en high every gap-th cycle. Optionally keeps
    // in_valid high with another value during the window.
    task automatic run_sample(input logic [7:0] v, input int gap, input bit hold,
                              input logic [7:0] hv, input string tag);
        int   steps = 0;
        int   cyc   = 0;
        int   cnt   = 0;
        logic f;
        in_valid = 1'b1;
        in_value = v;
        step_en  = 1'b1;
        tick();
        check({tag, "_accept_busy"}, 32'(busy), 32'd1);
        check({tag, "_accept_ready"}, 32'(in_ready), 32'd0);
        if (hold) in_value = hv;
        else      in_valid = 1'b0;
        while (steps < STEPS && cyc < STEPS * gap + 8) begin
            step_en = ((cyc % gap) == 0);
            f = step_en && fire_m(v, m_lfsr);
            tick();
            if (step_en) begin
                m_lfsr = lfsr_step(m_lfsr);
                steps++;
                cnt += int'(f);
            end
            check({tag, "_spike"}, 32'(spike_out), 32'(f));
            check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
            check({tag, "_done"}, 32'(done), 32'(steps == STEPS));
            cyc++;
        end
        check({tag, "_step_budget"}, 32'(steps), 32'(STEPS));
        check({tag, "_count"}, 32'(spike_count), 32'(cnt));
        step_en = 1'b1;
        tick();
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_done_after"}, 32'(done), 32'd0);
        check({tag, "_spike_after"}, 32'(spike_out), 32'd0);
        check({tag, "_count_held"}, 32'(spike_count), 32'(cnt));
    endtask

    initial begin
        logic f;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        step_en  = 1'b0;
        m_lfsr   = SEED;
        tick();
        tick();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_spike", 32'(spike_out), 32'd0);
        check("rst_count", 32'(spike_count), 32'd0);
        rst_n = 1'b1;

        // step_en in IDLE must not advance the LFSR
        step_en = 1'b1;
        tick();
        tick();
        check("idle_spike", 32'(spike_out), 32'd0);

        run_sample(8'd0, 1, 1'b0, 8'd0, "v0");
        check("v0_total", 32'(spike_count), 32'd0);
        run_sample(8'd255, 1, 1'b0, 8'd0, "v255");
        check("v255_total", 32'(spike_count), 32'd16);

        for (int i = 0; i < 4; i++) run_sample(8'd128, 1, 1'b0, 8'd0, "v128");

        run_sample(8'd200, 3, 1'b0, 8'd0, "v200gap");

        run_sample(8'd100, 1, 1'b1, 8'd50, "v100hold");
        run_sample(8'd50, 1, 1'b0, 8'd0, "v50");

        // Reset in the middle of a window
        in_valid = 1'b1;
        in_value = 8'd128;
        step_en  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            f = fire_m(8'd128, m_lfsr);
            tick();
            m_lfsr = lfsr_step(m_lfsr);
            check("pre_rst_spike", 32'(spike_out), 32'(f));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_spike", 32'(spike_out), 32'd0);
        check("mid_rst_count", 32'(spike_count), 32'd0);
        tick();
        check("mid_rst_done_hold", 32'(done), 32'd0);
        rst_n  = 1'b1;
        m_lfsr = SEED;
        // From SEED: draw 0xE1 > 128 -> no spike; next draw 0x70 < 128 -> spike
        check("seed_draw0", 32'(fire_m(8'd128, m_lfsr)), 32'd0);
        check("seed_draw1", 32'(fire_m(8'd128, lfsr_step(m_lfsr))), 32'd1);
        run_sample(8'd128, 1, 1'b0, 8'd0, "v128_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
